// File: rtl/edge_event_arbiter.sv
// Rising-edge detector with per-channel saturating counters and a round-robin valid/ready event port.
// Optional sticky overflow flags (ovf_o / ovf_clr_i) are built when EDGE_ARB_OVERFLOW_EN is defined.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic [NUM_CH-1:0] pending_o
`ifdef EDGE_ARB_OVERFLOW_EN
  ,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic [NUM_CH-1:0] ovf_clr_i
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] a_ff;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pop;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   idx;
  logic              gnt_found;
  logic              load;

  // Saturating count update: a coincident rise and pop cancel, so a full counter
  // that is popped while an edge arrives keeps that edge.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic r,
                                                input logic p);
    if (r && !p)
      return (cur == CNT_MAX) ? cur : cur + 1'b1;
    else if (!r && p)
      return cur - 1'b1;
    return cur;
  endfunction

  assign rise = a_i & ~a_ff;
  assign load = ~evt_valid_o | evt_ready_i;

  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = last;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last) + k) % NUM_CH);
      if (!gnt_found && cnt[idx] != '0) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && gnt_found)
      pop[gnt_ch] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      pending_o[c] = (cnt[c] != '0);
  end

  // Stage: input history and per-channel counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ff <= '0;
      for (int c = 0; c < NUM_CH; c++)
        cnt[c] <= '0;
    end else begin
      a_ff <= a_i;
      for (int c = 0; c < NUM_CH; c++)
        cnt[c] <= cnt_next(cnt[c], rise[c], pop[c]);
    end
  end

  // Stage: presented event register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid_o <= 1'b0;
      evt_ch_o    <= '0;
      last        <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      if (gnt_found) begin
        evt_valid_o <= 1'b1;
        evt_ch_o    <= gnt_ch;
        last        <= gnt_ch;
      end else begin
        evt_valid_o <= 1'b0;
      end
    end
  end

`ifdef EDGE_ARB_OVERFLOW_EN
  logic [NUM_CH-1:0] cnt_full;
  logic [NUM_CH-1:0] drop;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      cnt_full[c] = (cnt[c] == CNT_MAX);
  end

  assign drop = rise & ~pop & cnt_full;

  // Stage: sticky overflow flags, a new drop outranks a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf_o <= '0;
    else
      ovf_o <= (ovf_o & ~ovf_clr_i) | drop;
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed plus randomized bench for edge_event_arbiter against a cycle-level counting model.
// Build with EDGE_ARB_OVERFLOW_EN defined to also exercise the overflow flags.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic         clk;
  logic         reset;
  logic [N-1:0] a;
  logic         evt_valid;
  logic         ready;
  logic [1:0]   evt_ch;
  logic [N-1:0] pending;
  logic [N-1:0] clr;
`ifdef EDGE_ARB_OVERFLOW_EN
  logic [N-1:0] ovf;
`endif

  edge_event_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_i        (a),
    .evt_valid_o(evt_valid),
    .evt_ready_i(ready),
    .evt_ch_o   (evt_ch),
    .pending_o  (pending)
`ifdef EDGE_ARB_OVERFLOW_EN
    ,
    .ovf_o      (ovf),
    .ovf_clr_i  (clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer pending counts per channel
  int           m_cnt [N];
  logic [N-1:0] m_prev;
  logic [N-1:0] m_ovf;
  int           m_last;
  bit           m_valid;
  int           m_ch;
  int           acc_q [$];
  int           exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_cnt[c] = 0;
    m_prev  = '0;
    m_ovf   = '0;
    m_last  = N - 1;
    m_valid = 1'b0;
    m_ch    = 0;
  endtask

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = (m_cnt[c] != 0);
    return v;
  endfunction

  task automatic cycle();
    bit ld, found;
    int g, r, p, n, c;
    logic [N-1:0] nxt_ovf;
    if (evt_valid === 1'b1 && ready === 1'b1) acc_q.push_back(int'(evt_ch));
    ld = !m_valid || ready;
    found = 0;
    g = 0;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (!found && m_cnt[c] > 0) begin
        found = 1;
        g = c;
      end
    end
    nxt_ovf = m_ovf & ~clr;
    for (int ch = 0; ch < N; ch++) begin
      r = (a[ch] && !m_prev[ch]) ? 1 : 0;
      p = (ld && found && g == ch) ? 1 : 0;
      n = m_cnt[ch] + r - p;
      if (n > MAXC) begin
        n = MAXC;
        nxt_ovf[ch] = 1'b1;
      end
      m_cnt[ch] = n;
    end
    m_ovf  = nxt_ovf;
    m_prev = a;
    if (ld) begin
      if (found) begin
        m_valid = 1'b1;
        m_ch    = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", evt_valid, m_valid);
    chk("ch", evt_ch, m_ch);
    chk("pending", pending, m_pending());
`ifdef EDGE_ARB_OVERFLOW_EN
    chk("ovf", ovf, m_ovf);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ch", evt_ch, 0);
`ifdef EDGE_ARB_OVERFLOW_EN
    chk("rst_ovf", ovf, 0);
`endif
    model_reset();
    a = '0;
    ready = 1'b0;
    clr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_q.delete();
  endtask

  task automatic chk_events(input string tag);
    chk({tag, "_count"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk({tag, "_ch"}, acc_q[i], exp_q[i]);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    a = v;
    run(1);
    a = '0;
    run(1);
  endtask

  initial begin
    int n3;
    reset = 1'b1;
    a = '0;
    ready = 1'b0;
    clr = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single edge on ch2, held high
    ready = 1'b1;
    a = 4'b0100;
    run(1);
    chk("single_lat1", evt_valid, 0);
    run(1);
    chk("single_lat2", evt_valid, 1);
    chk("single_ch", evt_ch, 2);
    run(6);
    exp_q = {2};
    chk_events("single");
    a = '0;
    run(2);

    // Stall and accumulate three pulses on ch1
    ready = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 3; i++) pulse(4'b0010);
    chk("stall_pending", pending, 4'b0010);
    ready = 1'b1;
    run(3);
    exp_q = {1, 1, 1};
    chk_events("stall");
    chk("stall_drained", pending, 0);
    chk("stall_idle", evt_valid, 0);

    // Round-robin order from a fresh pointer
    do_reset();
    a = 4'b1111;
    run(1);
    a = '0;
    run(1);
    ready = 1'b1;
    a = 4'b0001;
    run(1);
    a = '0;
    run(6);
    exp_q = {0, 1, 2, 3, 0};
    chk_events("rr");

    // Stability while stalled
    ready = 1'b0;
    pulse(4'b0100);
    chk("stab_valid0", evt_valid, 1);
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 4'b1011 : 4'b0000;
      run(1);
      chk("stab_ch", evt_ch, 2);
      chk("stab_valid", evt_valid, 1);
    end
    a = '0;
    ready = 1'b1;
    run(20);
    chk("stab_drained", pending, 0);

    // Saturation on ch3 behind an already-presented ch0 event
    ready = 1'b0;
    pulse(4'b0001);
    for (int i = 0; i < 9; i++) pulse(4'b1000);
    chk("sat_pending", pending, 4'b1000);
`ifdef EDGE_ARB_OVERFLOW_EN
    chk("sat_ovf", ovf[3], 1);
    clr = 4'b1000;
    a = 4'b1000;
    run(1);
    chk("ovf_set_wins", ovf[3], 1);
    a = '0;
    run(1);
    chk("ovf_cleared", ovf[3], 0);
    clr = '0;
`endif
    acc_q.delete();
    ready = 1'b1;
    run(12);
    n3 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 3) n3++;
    chk("sat_ch3_events", n3, MAXC);
    chk("sat_total", acc_q.size(), MAXC + 1);

    // Asynchronous reset with work outstanding
    ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(4'b0001);
    chk("mid_valid", evt_valid, 1);
    chk("mid_pending", pending, 4'b0001);
    do_reset();
    ready = 1'b1;
    run(5);
    chk("mid_no_events", acc_q.size(), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = N'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      run(1);
    end
    clr = '0;
    a = '0;
    ready = 1'b1;
    run(40);
    chk("final_drained", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
